// File: rtl/ext_pkg.sv
// Shared opcodes, field widths and helpers for the immediate-extension stage.
package ext_pkg;

    localparam int unsigned EXT_OP_W   = 3;
    localparam int unsigned INST_IMM_W = 26;

    localparam logic [EXT_OP_W-1:0] EXT_20  = 3'd0;
    localparam logic [EXT_OP_W-1:0] EXT_12  = 3'd1;
    localparam logic [EXT_OP_W-1:0] EXT_12U = 3'd2;
    localparam logic [EXT_OP_W-1:0] EXT_5   = 3'd3;
    localparam logic [EXT_OP_W-1:0] EXT_16  = 3'd4;
    localparam logic [EXT_OP_W-1:0] EXT_26  = 3'd5;

    // Opcodes 6 and 7 have no defined format.
    function automatic logic is_reserved_op(input logic [EXT_OP_W-1:0] op);
        return (op > EXT_26);
    endfunction

endpackage

// File: rtl/ext_fmt.sv
// Combinational LA32R immediate formatter: builds a 32-bit result, then widens to DATA_W.
module ext_fmt
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [INST_IMM_W-1:0] din,
    input  logic [EXT_OP_W-1:0]   ext_op,
    output logic [DATA_W-1:0]     ext,
    output logic                  op_err
);

    logic [31:0] r32;
    logic        sext;

    // Select the format, then replicate R[31] above bit 31 for signed formats.
    always_comb begin
        r32    = '0;
        sext   = 1'b0;
        op_err = 1'b0;
        ext    = '0;
        unique case (ext_op)
            EXT_20:  begin r32 = {din[24:5], 12'h000};                          sext = 1'b1; end
            EXT_12:  begin r32 = {{20{din[21]}}, din[21:10]};                   sext = 1'b1; end
            EXT_12U: begin r32 = {20'h00000, din[21:10]};                                    end
            EXT_5:   begin r32 = {27'h0000000, din[14:10]};                                  end
            EXT_16:  begin r32 = {{14{din[25]}}, din[25:10], 2'b00};            sext = 1'b1; end
            EXT_26:  begin r32 = {{4{din[9]}}, din[9:0], din[25:10], 2'b00};    sext = 1'b1; end
            default: begin r32 = {6'h00, din};                                  op_err = 1'b1; end
        endcase
        ext = DATA_W'(r32);
        if (sext && r32[31]) begin
            ext = ext | ~DATA_W'(32'hFFFF_FFFF);
        end
    end

endmodule

// File: rtl/ext_stage.sv
// Buffered immediate-extension stage: formats at the input, queues results in a DEPTH-entry FIFO.
module ext_stage
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 32
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INST_IMM_W-1:0]     in_din,
    input  logic [EXT_OP_W-1:0]       in_ext_op,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_ext,
    output logic                      out_op_err,
    output logic [TAG_W-1:0]          out_tag,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    if (DATA_W < 32) begin : g_bad_width
        $error("ext_stage: DATA_W must be at least 32");
    end

    logic [DATA_W-1:0] mem_ext [DEPTH];
    logic              mem_err [DEPTH];
    logic [TAG_W-1:0]  mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] occ_nxt;

    logic [DATA_W-1:0] fmt_ext;
    logic              fmt_err;
    logic              push;
    logic              pop;

    ext_fmt #(.DATA_W(DATA_W)) u_fmt (
        .din    (in_din),
        .ext_op (in_ext_op),
        .ext    (fmt_ext),
        .op_err (fmt_err)
    );

    assign in_ready  = (occupancy < DEPTH_C);
    assign out_valid = (occupancy != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head entry drives the outputs; masked to zero while empty.
    assign out_ext    = out_valid ? mem_ext[rd_ptr] : '0;
    assign out_op_err = out_valid ? mem_err[rd_ptr] : 1'b0;
    assign out_tag    = out_valid ? mem_tag[rd_ptr] : '0;

    // Next pointer/occupancy; reset and flush discard any same-cycle push or pop.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        occ_nxt    = occupancy;
        if (cpu_rst || flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            occ_nxt    = '0;
        end else begin
            if (push) begin
                wr_ptr_nxt = (wr_ptr == LAST_P) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_nxt = (rd_ptr == LAST_P) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ_nxt = occupancy + CNT_W'(1);
            end else if (pop && !push) begin
                occ_nxt = occupancy - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge cpu_clk) begin
        wr_ptr    <= wr_ptr_nxt;
        rd_ptr    <= rd_ptr_nxt;
        occupancy <= occ_nxt;
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge cpu_clk) begin
        if (push && !flush && !cpu_rst) begin
            mem_ext[wr_ptr] <= fmt_ext;
            mem_err[wr_ptr] <= fmt_err;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // Occupancy must never wrap past full or below empty.
    a_no_overflow: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        !(push && !pop && occupancy == DEPTH_C));
    a_no_underflow: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
        !(pop && occupancy == '0));

endmodule

// File: doc/ext_stage.md
Name: ext_stage

Overview:
Parametrised, buffered immediate-extension stage for the LA32R core.
- Accepts raw instruction immediate fields (inst[25:0]) plus a format opcode and a passthrough tag over a valid/ready handshake.
- Formats the immediate to DATA_W bits and queues results in a DEPTH-entry FIFO toward the next pipeline stage.
- Extends the 3-format extender with the full LA32R immediate set, wider datapaths, illegal-op flagging, back-pressure and flush.

Parameters:
- DATA_W, 32, output immediate width; must be >= 32; sign bit replicated above bit 31.
- DEPTH, 2, result FIFO entries; power of two, 1..16.
- TAG_W, 32, width of passthrough tag (typically PC).

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued entries (pipeline redirect).
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept this cycle.
- in_din  in  26  instruction bits [25:0].
- in_ext_op  in  3  format select.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head.
- out_ext  out  DATA_W  extended immediate.
- out_op_err  out  1  head entry used a reserved ext_op.
- out_tag  out  TAG_W  tag of head entry.
- occupancy  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Clock and reset: one clock, cpu_clk. Reset is synchronous, active-high on cpu_rst, same cycle semantics as flush.
- Formats (R = 32-bit result, then sign-extended from R[31] to DATA_W unless marked zero):
  - 0 EXT_20: R = {din[24:5], 12'h000}.
  - 1 EXT_12: sign-extend din[21:10].
  - 2 EXT_12U: zero-extend din[21:10] to DATA_W.
  - 3 EXT_5: zero-extend din[14:10] to DATA_W.
  - 4 EXT_16: sign-extend {din[25:10], 2'b00}.
  - 5 EXT_26: sign-extend {din[9:0], din[25:10], 2'b00}.
  - 6, 7 reserved: zero-extend din to DATA_W, op_err = 1.
- Formatting is combinational at the input; the result is written into the FIFO on push.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (occupancy < DEPTH). It is registered-state only, with no combinational path from out_ready. A full FIFO therefore accepts nothing, even if a pop occurs the same cycle.
- out_valid = (occupancy != 0). out_ext/out_op_err/out_tag come from the head entry and are stable while out_valid & !out_ready.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1 when the FIFO was empty. There is no combinational bypass.
- Simultaneous push and pop (not full, not empty): occupancy unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. occupancy saturates nowhere; an assertion fires on overflow or underflow.
- flush or cpu_rst: next cycle occupancy = 0, pointers = 0, out_valid = 0, in_ready = 1. A push or pop in the same cycle is discarded.
- Reset values: out_valid 0, in_ready 1, occupancy 0. out_ext, out_tag and out_op_err are 0 (storage cleared or output masked while empty).
- Reset asserted mid-stream behaves identically to flush. in_valid need not drop.

Decomposition:
- Package ext_pkg:
  - EXT_20..EXT_26 opcode localparams (3-bit).
  - EXT_OP_W = 3.
  - INST_IMM_W = 26.
  - Function/constant for the reserved-op check.
- Sub-module ext_fmt: pure combinational formatter (din, ext_op -> ext[DATA_W-1:0], op_err), parametrised by DATA_W.
- FIFO storage and pointers live in ext_stage.

Test Plan:
- Reset, then EXT_12 with din = 26'h0200000, out_ready = 1 -> next cycle out_valid = 1, out_ext = 32'hFFFFF800, out_op_err = 0.
- EXT_20 din = 26'h02468A0 -> 32'h12345000. EXT_26 din = 26'h00007FF -> 32'hFFFC0004. EXT_16 din = 26'h3FFFC00 -> 32'hFFFFFFFC. EXT_12U din = 26'h0200000 -> 32'h00000800.
- DATA_W = 64, EXT_16 din = 26'h3FFFC00 -> 64'hFFFFFFFF_FFFFFFFC. ext_op = 3'd7, din = 26'h3FFFFFF -> 64'h00000000_03FFFFFF, out_op_err = 1.
- DEPTH = 2, out_ready = 0, push 3 entries back-to-back -> in_ready drops after 2 pushes, occupancy = 2. The third entry is held upstream. Release out_ready -> entries emerge in order, tags preserved.
- Flush with occupancy = 2 and concurrent push -> next cycle occupancy = 0, out_valid = 0, in_ready = 1, the pushed entry never appears.
- Random valid/ready streams (10k ops) vs scoreboard model -> no loss, duplication or reordering; outputs stable under stall.
